// File: rtl/apu_pkg.sv
// Shared APU constants: register addresses, noise period tables and length table.
package apu_pkg;
    localparam logic [1:0] ADDR_400C = 2'd0;
    localparam logic [1:0] ADDR_400E = 2'd2;
    localparam logic [1:0] ADDR_400F = 2'd3;

    localparam logic [11:0] NOISE_PERIOD_NTSC [16] = '{
        12'd4, 12'd8, 12'd16, 12'd32, 12'd64, 12'd96, 12'd128, 12'd160,
        12'd202, 12'd254, 12'd380, 12'd508, 12'd762, 12'd1016, 12'd2034, 12'd4068
    };

    localparam logic [11:0] NOISE_PERIOD_PAL [16] = '{
        12'd4, 12'd8, 12'd14, 12'd30, 12'd60, 12'd88, 12'd118, 12'd148,
        12'd188, 12'd236, 12'd354, 12'd472, 12'd708, 12'd944, 12'd1890, 12'd3778
    };

    localparam logic [7:0] LEN_TABLE [32] = '{
        8'd10, 8'd254, 8'd20, 8'd2, 8'd40, 8'd4, 8'd80, 8'd6,
        8'd160, 8'd8, 8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
        8'd12, 8'd16, 8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
        8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
    };

    function automatic logic [11:0] noise_period(input logic pal, input logic [3:0] idx);
        return pal ? NOISE_PERIOD_PAL[idx] : NOISE_PERIOD_NTSC[idx];
    endfunction
endpackage

// File: rtl/noise_channel_if.sv
// CPU-side register write port of the noise channel.
interface noise_channel_if;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/apu_envelope.sv
// Envelope unit (start flag, divider, decay level); shared with the pulse channels.
module apu_envelope (
    input  logic       clk,
    input  logic       rst,
    input  logic       qframe_i,
    input  logic       start_set_i,
    input  logic       loop_i,
    input  logic [3:0] n_i,
    output logic [3:0] decay_o
);
    logic       start_q;
    logic [3:0] div_q;
    logic [3:0] decay_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
            div_q   <= 4'd0;
            decay_q <= 4'd0;
        end else begin
            if (qframe_i) begin
                if (start_q) begin
                    start_q <= 1'b0;
                    decay_q <= 4'd15;
                    div_q   <= n_i;
                end else if (div_q == 4'd0) begin
                    div_q <= n_i;
                    if (decay_q != 4'd0)
                        decay_q <= decay_q - 4'd1;
                    else if (loop_i)
                        decay_q <= 4'd15;
                end else begin
                    div_q <= div_q - 4'd1;
                end
            end
            // A same-cycle restart is seen by the following qframe, not this one.
            if (start_set_i)
                start_q <= 1'b1;
        end
    end

    assign decay_o = decay_q;
endmodule

// File: rtl/noise_channel.sv
// APU noise channel: register port, period timer, LFSR, envelope and length counter.
module noise_channel
    import apu_pkg::*;
#(
    parameter int LFSR_W    = 15,
    parameter int TAP_LONG  = 1,
    parameter int TAP_SHORT = 6,
    parameter int TIMER_W   = 12,
    parameter int PAL       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             apu_ce,
    input  logic             qframe,
    input  logic             hframe,
    noise_channel_if.slave   wr,
    input  logic             ch_enable,
    output logic [3:0]       vol,
    output logic             len_active
);
    logic               halt_q, const_q, mode_q;
    logic [3:0]         n_q, pidx_q, vol_q, vol_d, decay;
    logic [7:0]         length_q, length_d;
    logic [TIMER_W-1:0] timer_q, timer_d, period;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic               wr_c, wr_e, wr_f, fb;

    assign wr_c   = wr.wr_en && (wr.wr_addr == ADDR_400C);
    assign wr_e   = wr.wr_en && (wr.wr_addr == ADDR_400E);
    assign wr_f   = wr.wr_en && (wr.wr_addr == ADDR_400F);
    assign period = TIMER_W'(noise_period(PAL != 0, pidx_q));
    assign fb     = lfsr_q[0] ^ (mode_q ? lfsr_q[TAP_SHORT] : lfsr_q[TAP_LONG]);

    apu_envelope u_env (
        .clk         (clk),
        .rst         (rst),
        .qframe_i    (qframe),
        .start_set_i (wr_f),
        .loop_i      (halt_q),
        .n_i         (n_q),
        .decay_o     (decay)
    );

    // Channel disable beats a load, and a load beats the half-frame decrement.
    always_comb begin
        length_d = length_q;
        if (!ch_enable)
            length_d = 8'd0;
        else if (wr_f)
            length_d = LEN_TABLE[wr.wr_data[7:3]];
        else if (hframe && (length_q != 8'd0) && !halt_q)
            length_d = length_q - 8'd1;
    end

    always_comb begin
        timer_d = timer_q;
        lfsr_d  = lfsr_q;
        if (apu_ce) begin
            if (timer_q == '0) begin
                timer_d = period - TIMER_W'(1);
                lfsr_d  = {fb, lfsr_q[LFSR_W-1:1]};
            end else begin
                timer_d = timer_q - TIMER_W'(1);
            end
        end
    end

    always_comb begin
        vol_d = const_q ? n_q : decay;
        if (lfsr_q[0] || (length_q == 8'd0))
            vol_d = 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q   <= 1'b0;
            const_q  <= 1'b0;
            n_q      <= 4'd0;
            mode_q   <= 1'b0;
            pidx_q   <= 4'd0;
            length_q <= 8'd0;
            timer_q  <= '0;
            lfsr_q   <= LFSR_W'(1);
            vol_q    <= 4'd0;
        end else begin
            if (wr_c) begin
                halt_q  <= wr.wr_data[5];
                const_q <= wr.wr_data[4];
                n_q     <= wr.wr_data[3:0];
            end
            if (wr_e) begin
                mode_q <= wr.wr_data[7];
                pidx_q <= wr.wr_data[3:0];
            end
            length_q <= length_d;
            timer_q  <= timer_d;
            lfsr_q   <= lfsr_d;
            vol_q    <= vol_d;
        end
    end

    assign vol        = vol_q;
    assign len_active = (length_q != 8'd0);
endmodule

// File: tb/tb_noise_channel.sv
// Self-checking bench for noise_channel: LFSR scoreboard, envelope and length tables.
`timescale 1ns/1ps
module tb_noise_channel;
    logic       clk = 1'b0;
    logic       rst, apu_ce, qframe, hframe, ch_enable;
    logic [3:0] vol;
    logic       len_active;

    noise_channel_if wif();

    noise_channel dut (
        .clk        (clk),
        .rst        (rst),
        .apu_ce     (apu_ce),
        .qframe     (qframe),
        .hframe     (hframe),
        .wr         (wif),
        .ch_enable  (ch_enable),
        .vol        (vol),
        .len_active (len_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] idx;
        int         len;
    } lvec_t;

    int         nvec = 0;
    int         nerr = 0;
    logic [3:0] exp_q[$];
    int         len_q[$];
    logic [14:0] m;
    int         mt, per;
    logic       mmode;
    lvec_t      lv[32];
    int         lens[32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                             12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic h = 1'b0,
                      input logic q = 1'b0);
        wif.wr_en = 1'b1; wif.wr_addr = a; wif.wr_data = d;
        hframe = h; qframe = q;
        tick();
        wif.wr_en = 1'b0; hframe = 1'b0; qframe = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m = 15'd1; mt = 0; per = 4; mmode = 1'b0;
    endtask

    task automatic ce_once();
        apu_ce = 1'b1;
        tick();
        apu_ce = 1'b0;
    endtask

    task automatic qf();
        qframe = 1'b1;
        tick();
        qframe = 1'b0;
        tick();
    endtask

    task automatic hf();
        hframe = 1'b1;
        tick();
        hframe = 1'b0;
    endtask

    function automatic logic [14:0] lstep(input logic [14:0] s, input logic md);
        logic b;
        b = s[0] ^ (md ? s[6] : s[1]);
        return {b, s[14:1]};
    endfunction

    // Runs n apu_ce cycles; with const n=15 and length loaded, vol mirrors ~lfsr[0].
    task automatic run_ce(input int n);
        logic [3:0] e;
        exp_q.push_back(m[0] ? 4'd0 : 4'd15);
        for (int k = 0; k < n; k++) begin
            apu_ce = 1'b1;
            tick();
            e = exp_q.pop_front();
            chk("vol_lfsr", vol, e);
            if (mt == 0) begin
                mt = per - 1;
                m = lstep(m, mmode);
            end else begin
                mt--;
            end
            exp_q.push_back(m[0] ? 4'd0 : 4'd15);
        end
        apu_ce = 1'b0;
        tick();
        e = exp_q.pop_front();
        chk("vol_lfsr_tail", vol, e);
    endtask

    task automatic env_run(input bit loop_mode);
        int         e;
        logic [3:0] ev;
        for (int q = 1; q <= 100; q++) begin
            qframe = 1'b1;
            tick();
            qframe = 1'b0;
            e = 15 - (q - 1) / 6;
            if (loop_mode) e = e & 15;
            else if (e < 0) e = 0;
            exp_q.push_back(4'(e));
            tick();
            ev = exp_q.pop_front();
            chk(loop_mode ? "env_loop" : "env_decay", vol, ev);
        end
    endtask

    task automatic count_len(input string nm);
        int cnt, e;
        cnt = 0;
        while (len_active && cnt < 300) begin
            hf();
            cnt++;
        end
        e = len_q.pop_front();
        chk(nm, cnt, e);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            lv[i].idx = 5'(i);
            lv[i].len = lens[i];
        end
        rst = 1'b1; apu_ce = 1'b0; qframe = 1'b0; hframe = 1'b0; ch_enable = 1'b0;
        wif.wr_en = 1'b0; wif.wr_addr = 2'd0; wif.wr_data = 8'd0;
        do_reset();
        chk("reset_vol", vol, 4'd0);
        chk("reset_len_active", len_active, 1'b0);

        // Long mode, period 4.
        ch_enable = 1'b1;
        wr(2'd0, 8'h3F);
        wr(2'd2, 8'h00);
        wr(2'd3, 8'h08);
        chk("len_active_254", len_active, 1'b1);
        run_ce(200);

        // Short mode from reset, then period index 1 mid-count.
        do_reset();
        ch_enable = 1'b1;
        wr(2'd0, 8'h3F);
        wr(2'd2, 8'h80);
        mmode = 1'b1;
        wr(2'd3, 8'h08);
        run_ce(400);
        wr(2'd2, 8'h81);
        per = 8;
        run_ce(100);

        // Envelope decay and loop.
        do_reset();
        ch_enable = 1'b1;
        ce_once();
        wr(2'd0, 8'h05);
        wr(2'd3, 8'h08);
        env_run(1'b0);
        wr(2'd0, 8'h25);
        wr(2'd3, 8'h08);
        env_run(1'b1);

        // $400F write on the same clk as qframe: old start flag is processed.
        do_reset();
        ch_enable = 1'b1;
        ce_once();
        wr(2'd0, 8'h05);
        wr(2'd3, 8'h08);
        for (int i = 0; i < 7; i++) qf();
        chk("env_pre", vol, 4'd14);
        wr(2'd3, 8'h08, 1'b0, 1'b1);
        tick();
        chk("env_same_clk_old_start", vol, 4'd14);
        qf();
        chk("env_restart_next_q", vol, 4'd15);

        // Full length table.
        wr(2'd0, 8'h1F);
        foreach (lv[i]) begin
            wr(2'd3, {lv[i].idx, 3'b000});
            len_q.push_back(lv[i].len);
            count_len("len_table");
            tick();
            chk("len_zero_vol", vol, 4'd0);
        end

        // Halt holds the counter.
        wr(2'd0, 8'h3F);
        wr(2'd3, 8'h18);
        hf();
        hf();
        chk("halt_hold", len_active, 1'b1);
        wr(2'd0, 8'h1F);
        hf();
        chk("unhalt_1", len_active, 1'b1);
        hf();
        chk("unhalt_2", len_active, 1'b0);
        tick();
        chk("unhalt_vol", vol, 4'd0);

        // Channel disable.
        ch_enable = 1'b0;
        wr(2'd3, 8'h08);
        chk("disabled_load", len_active, 1'b0);
        ch_enable = 1'b1;
        wr(2'd3, 8'h00);
        chk("enabled_load", len_active, 1'b1);
        ch_enable = 1'b0;
        tick();
        chk("disable_clears", len_active, 1'b0);
        ch_enable = 1'b1;

        // Load on the same clk as hframe: no decrement.
        wr(2'd3, 8'h00, 1'b1, 1'b0);
        len_q.push_back(10);
        count_len("load_with_hframe");

        // Mid-run reset.
        wr(2'd0, 8'h1F);
        wr(2'd3, 8'h08);
        tick();
        chk("pre_reset_vol", vol, 4'd15);
        rst = 1'b1;
        tick();
        chk("midreset_vol", vol, 4'd0);
        chk("midreset_len", len_active, 1'b0);
        rst = 1'b0;
        wr(2'd0, 8'h3F);
        wr(2'd3, 8'h08);
        tick();
        chk("post_reset_lfsr1", vol, 4'd0);
        ce_once();
        tick();
        chk("post_reset_first_step", vol, 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
